// File: rtl/load_store_pipe_pkg.sv
// Shared types for the load/store pipe: access-size encoding, FSM states
// and the result-queue entry carried to the common data buses.
package load_store_pipe_pkg;

  localparam int LS_XLEN  = 32;
  localparam int LS_RRN_W = 6;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } ls_size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } ls_state_e;

  typedef struct packed {
    logic [LS_XLEN-1:0]  data;
    logic [LS_XLEN-1:0]  pc;
    logic [LS_RRN_W-1:0] rrn;
    logic                we;
    logic                exc;
  } ls_entry_t;

endpackage

// File: rtl/ls_result_queue.sv
// ls_result_queue: circular result FIFO with one push and up to NPOP pops
// per cycle. head[k] always shows the k-th oldest entry so the bus logic
// can hand out several entries at once; pop_cnt removes that many.
module ls_result_queue
  import load_store_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NPOP  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  ls_entry_t                  push_entry,
  input  logic [$clog2(DEPTH+1)-1:0] pop_cnt,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output ls_entry_t                  head [NPOP]
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  ls_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = count_q + CNT_W'(push) - pop_cnt;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  // Oldest-first view of the queue head.
  always_comb begin
    for (int k = 0; k < NPOP; k++) begin
      head[k] = mem_q[rd_ptr_q + PTR_W'(k)];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/load_store_pipe.sv
// load_store_pipe: single-outstanding load/store unit. An accepted
// operation is held in ACCESS until the data cache acknowledges it; the
// result is queued and broadcast on any common data bus whose arbiter
// selects this unit. Datapath widths follow load_store_pipe_pkg.
// Build option: define LS_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as exceptions instead of silently aligning the address.
module load_store_pipe
  import load_store_pipe_pkg::*;
#(
  parameter int         XLEN            = 32,
  parameter int         BUS_COUNT       = 2,
  parameter int         QUEUE_DEPTH     = 4,
  parameter int         RRN_WIDTH       = 6,
  parameter logic [3:0] ARBITER_ADDRESS = 4'h3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                feed_valid,
  output logic                                feed_ready,
  input  logic [XLEN-1:0]                     feed_base,
  input  logic [XLEN-1:0]                     feed_data,
  input  logic [XLEN-1:0]                     feed_offset,
  input  logic [XLEN-1:0]                     feed_pc,
  input  logic [RRN_WIDTH-1:0]                feed_rrn,
  input  logic                                feed_store,
  input  logic [1:0]                          feed_size,
  input  logic                                feed_unsigned,
  output logic                                dc_req,
  output logic                                dc_we,
  output logic [XLEN-1:0]                     dc_addr,
  output logic [XLEN-1:0]                     dc_wdata,
  output logic [3:0]                          dc_be,
  input  logic                                dc_ack,
  input  logic [XLEN-1:0]                     dc_rdata,
  input  logic [BUS_COUNT-1:0][3:0]           bus_select,
  output logic [BUS_COUNT-1:0]                bus_req,
  output logic [BUS_COUNT-1:0]                cdb_drive,
  output logic [BUS_COUNT-1:0][XLEN-1:0]      cdb_data,
  output logic [BUS_COUNT-1:0][XLEN-1:0]      cdb_address,
  output logic [BUS_COUNT-1:0][RRN_WIDTH-1:0] cdb_rrn,
  output logic [BUS_COUNT-1:0]                cdb_we,
  output logic [BUS_COUNT-1:0]                cdb_exc
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH+1);

  function automatic logic [3:0] lane_mask(input ls_size_e size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << lo;
      SIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] replicate(input ls_size_e size, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (size)
      SIZE_BYTE: r = {(XLEN/8){d[7:0]}};
      SIZE_HALF: r = {(XLEN/16){d[15:0]}};
      default:   r = d;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0] lo,
                                                   input ls_size_e size,
                                                   input logic uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    sh = rdata >> {lo, 3'b000};
    case (size)
      SIZE_BYTE: r = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      SIZE_HALF: r = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      default:   r = rdata;
    endcase
    return r;
  endfunction

`ifdef LS_MISALIGN_TRAP_EN
  function automatic logic misaligned(input ls_size_e size, input logic [1:0] lo);
    logic m;
    case (size)
      SIZE_BYTE: m = 1'b0;
      SIZE_HALF: m = lo[0];
      default:   m = |lo;
    endcase
    return m;
  endfunction
`else
  function automatic logic [XLEN-1:0] align_addr(input ls_size_e size, input logic [XLEN-1:0] a);
    logic [XLEN-1:0] r;
    case (size)
      SIZE_BYTE: r = a;
      SIZE_HALF: r = {a[XLEN-1:1], 1'b0};
      default:   r = {a[XLEN-1:2], 2'b00};
    endcase
    return r;
  endfunction
`endif

  ls_state_e            state_q, state_d;
  logic                 trap_q, trap_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic                 store_q, store_d;
  ls_size_e             size_q, size_d;
  logic                 unsigned_q, unsigned_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [RRN_WIDTH-1:0] rrn_q, rrn_d;

  ls_size_e        feed_sz;
  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] op_addr;
  logic            op_trap;
  logic            accept;
  logic            done;
  logic            push;
  ls_entry_t       push_entry;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] pop_cnt;
  ls_entry_t       q_head [BUS_COUNT];

  assign feed_sz = ls_size_e'(feed_size);
  assign ea      = feed_base + feed_offset;

`ifdef LS_MISALIGN_TRAP_EN
  assign op_addr = ea;
  assign op_trap = misaligned(feed_sz, ea[1:0]);
`else
  assign op_addr = align_addr(feed_sz, ea);
  assign op_trap = 1'b0;
`endif

  // Ready only while idle with room for the result; a flush in the same
  // cycle wins over acceptance.
  assign feed_ready = reset && (state_q == ST_IDLE) && (q_count < CNT_W'(QUEUE_DEPTH));
  assign accept     = feed_valid && feed_ready && !flush;
  assign done       = (state_q == ST_ACCESS) && (trap_q || dc_ack);
  assign push       = done && !flush;

  // FSM next state and cache-request outputs; trapped accesses sit in
  // ACCESS for one cycle without requesting the cache.
  always_comb begin
    state_d  = state_q;
    trap_d   = trap_q;
    dc_req   = 1'b0;
    dc_we    = 1'b0;
    dc_addr  = '0;
    dc_wdata = '0;
    dc_be    = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACCESS;
          trap_d  = op_trap;
        end
      end
      ST_ACCESS: begin
        dc_req   = !trap_q;
        dc_we    = !trap_q && store_q;
        dc_addr  = trap_q ? '0 : addr_q;
        dc_wdata = trap_q ? '0 : wdata_q;
        dc_be    = trap_q ? '0 : be_q;
        if (flush || done) begin
          state_d = ST_IDLE;
          trap_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

  // Capture the accepted operation; held stable for the whole access.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    store_d    = store_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    pc_d       = pc_q;
    rrn_d      = rrn_q;
    if (accept) begin
      addr_d     = op_addr;
      wdata_d    = replicate(feed_sz, feed_data);
      be_d       = lane_mask(feed_sz, op_addr[1:0]);
      store_d    = feed_store;
      size_d     = feed_sz;
      unsigned_d = feed_unsigned;
      pc_d       = feed_pc;
      rrn_d      = feed_rrn;
    end
  end

  // Operation datapath registers (no reset; qualified by the FSM state).
  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    be_q       <= be_d;
    store_q    <= store_d;
    size_q     <= size_d;
    unsigned_q <= unsigned_d;
    pc_q       <= pc_d;
    rrn_q      <= rrn_d;
  end

  // Result entry built from the cache read word, or the trap address.
  always_comb begin
    push_entry      = '0;
    push_entry.pc   = pc_q;
    push_entry.rrn  = rrn_q;
    push_entry.exc  = trap_q;
    if (trap_q) begin
      push_entry.data = addr_q;
    end else if (!store_q) begin
      push_entry.data = load_extract(dc_rdata, addr_q[1:0], size_q, unsigned_q);
      push_entry.we   = 1'b1;
    end
  end

  ls_result_queue #(
    .DEPTH (QUEUE_DEPTH),
    .NPOP  (BUS_COUNT)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop_cnt    (pop_cnt),
    .count      (q_count),
    .head       (q_head)
  );

  // Bus requests and grants: the k-th granted bus (ascending index)
  // carries the k-th oldest entry; idle buses drive all zeros.
  always_comb begin
    int k;
    k           = 0;
    bus_req     = '0;
    cdb_drive   = '0;
    cdb_data    = '0;
    cdb_address = '0;
    cdb_rrn     = '0;
    cdb_we      = '0;
    cdb_exc     = '0;
    for (int i = 0; i < BUS_COUNT; i++) begin
      bus_req[i] = q_count > CNT_W'(i);
      if (bus_req[i] && (bus_select[i] == ARBITER_ADDRESS)) begin
        cdb_drive[i]   = 1'b1;
        cdb_data[i]    = q_head[k].data;
        cdb_address[i] = q_head[k].pc;
        cdb_rrn[i]     = q_head[k].rrn;
        cdb_we[i]      = q_head[k].we;
        cdb_exc[i]     = q_head[k].exc;
        k              = k + 1;
      end
    end
    pop_cnt = CNT_W'(k);
  end

endmodule

// File: tb/tb_load_store_pipe.sv
// Self-checking bench for load_store_pipe: directed vector table, hand
// sequences for queue fill/drain, flush, reset and misalignment, then a
// randomized run against a queue-based reference model.
module tb_load_store_pipe;

  localparam int BC = 2;

  logic              clk = 1'b0;
  logic              reset, flush, feed_valid, feed_ready;
  logic [31:0]       feed_base, feed_data, feed_offset, feed_pc;
  logic [5:0]        feed_rrn;
  logic              feed_store, feed_unsigned;
  logic [1:0]        feed_size;
  logic              dc_req, dc_we, dc_ack;
  logic [31:0]       dc_addr, dc_wdata, dc_rdata;
  logic [3:0]        dc_be;
  logic [BC-1:0][3:0]  bus_select;
  logic [BC-1:0]       bus_req, cdb_drive, cdb_we, cdb_exc;
  logic [BC-1:0][31:0] cdb_data, cdb_address;
  logic [BC-1:0][5:0]  cdb_rrn;

  always #5 clk = ~clk;

  load_store_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .feed_valid(feed_valid), .feed_ready(feed_ready),
    .feed_base(feed_base), .feed_data(feed_data), .feed_offset(feed_offset),
    .feed_pc(feed_pc), .feed_rrn(feed_rrn), .feed_store(feed_store),
    .feed_size(feed_size), .feed_unsigned(feed_unsigned),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_be(dc_be), .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .bus_select(bus_select), .bus_req(bus_req), .cdb_drive(cdb_drive),
    .cdb_data(cdb_data), .cdb_address(cdb_address), .cdb_rrn(cdb_rrn),
    .cdb_we(cdb_we), .cdb_exc(cdb_exc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic [5:0]  rrn;
    logic        we;
    logic        exc;
  } m_entry_t;

  m_entry_t mq[$];

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_trap(input logic [31:0] ea, input logic [1:0] size);
`ifdef LS_MISALIGN_TRAP_EN
    return (ea % nbytes(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] ea, input logic [1:0] size);
`ifdef LS_MISALIGN_TRAP_EN
    return ea;
`else
    return ea - (ea % nbytes(size));
`endif
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [1:0] size);
    int v;
    v = ((1 << nbytes(size)) - 1) << (addr % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] size);
    if (nbytes(size) == 1) return (d & 32'hFF) * 32'h01010101;
    if (nbytes(size) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] v, mask;
    int n;
    n = nbytes(size);
    if (n == 4) return rdata;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rdata >> (8 * (addr % 4))) & mask;
    if (!uns && v >= (32'd1 << (8 * n - 1))) v = v | ~mask;
    return v;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] base, off, data, rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_cdb;
    logic        e_we;
  } vec_t;

  vec_t vt [12];

  task automatic start_op(input logic store, input logic [1:0] size, input logic uns,
                          input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] data, input logic [31:0] pc, input logic [5:0] rrn);
    feed_store = store; feed_size = size; feed_unsigned = uns;
    feed_base = base; feed_offset = off; feed_data = data; feed_pc = pc; feed_rrn = rrn;
    feed_valid = 1'b1;
    #1;
    chk("start_ready", 32'(feed_ready), 32'd1);
    tick();
    feed_valid = 1'b0;
  endtask

  task automatic ack_op(input logic [31:0] rdata);
    dc_ack = 1'b1; dc_rdata = rdata;
    tick();
    dc_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; feed_valid = 1'b0;
    feed_base = '0; feed_data = '0; feed_offset = '0; feed_pc = '0; feed_rrn = '0;
    feed_store = 1'b0; feed_size = 2'd0; feed_unsigned = 1'b0;
    dc_ack = 1'b0; dc_rdata = '0; bus_select = '0;

    vt[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 32'h104, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h3, 32'h0, 32'h80123456, 32'h103, 4'h8, 32'h0, 32'hFFFFFF80, 1'b1};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 32'h100, 32'h3, 32'h0, 32'h80123456, 32'h103, 4'h8, 32'h0, 32'h00000080, 1'b1};
    vt[3]  = '{1'b1, 2'd1, 1'b0, 32'h0,   32'h2, 32'h1234, 32'h0, 32'h2, 4'hC, 32'h12341234, 32'h0, 1'b0};
    vt[4]  = '{1'b0, 2'd1, 1'b0, 32'h20,  32'h2, 32'h0, 32'h80017FFF, 32'h22, 4'hC, 32'h0, 32'hFFFF8001, 1'b1};
    vt[5]  = '{1'b0, 2'd1, 1'b1, 32'h20,  32'h0, 32'h0, 32'h1234F00D, 32'h20, 4'h3, 32'h0, 32'h0000F00D, 1'b1};
    vt[6]  = '{1'b1, 2'd0, 1'b0, 32'h0,   32'h1, 32'h123456AB, 32'h0, 32'h1, 4'h2, 32'hABABABAB, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h0, 32'hCAFEF00D, 32'h0, 32'h10, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0};
    vt[8]  = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h1, 32'h0, 32'h00007F00, 32'h101, 4'h2, 32'h0, 32'h0000007F, 1'b1};
    vt[9]  = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0BADF00D, 32'h4, 4'hF, 32'h0, 32'h0BADF00D, 1'b1};
    vt[10] = '{1'b0, 2'd0, 1'b1, 32'h200, 32'hFFFFFFFF, 32'h0, 32'h5A000000, 32'h1FF, 4'h8, 32'h0, 32'h0000005A, 1'b1};
    vt[11] = '{1'b0, 2'd1, 1'b0, 32'h40,  32'h0, 32'h0, 32'h0000FFFE, 32'h40, 4'h3, 32'h0, 32'hFFFFFFFE, 1'b1};

    // Reset state
    #3;
    chk("rst_dc_req", 32'(dc_req), 32'd0);
    chk("rst_dc_addr", dc_addr, 32'd0);
    chk("rst_dc_be", 32'(dc_be), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_cdb_drive", 32'(cdb_drive), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rst_feed_ready", 32'(feed_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      start_op(vt[i].store, vt[i].size, vt[i].uns, vt[i].base, vt[i].off, vt[i].data,
               32'h1000 + 32'(i * 4), 6'(i + 1));
      chk("tbl_dc_req", 32'(dc_req), 32'd1);
      chk("tbl_dc_addr", dc_addr, vt[i].e_addr);
      chk("tbl_dc_be", 32'(dc_be), 32'(vt[i].e_be));
      chk("tbl_dc_we", 32'(dc_we), 32'(vt[i].store));
      if (vt[i].store) chk("tbl_dc_wdata", dc_wdata, vt[i].e_wdata);
      chk("tbl_no_drive_yet", 32'(cdb_drive), 32'd0);
      ack_op(vt[i].rdata);
      chk("tbl_req_drop", 32'(dc_req), 32'd0);
      bus_select[0] = 4'h3;
      #1;
      chk("tbl_cdb_drive", 32'(cdb_drive), 32'd1);
      chk("tbl_cdb_data", cdb_data[0], vt[i].e_cdb);
      chk("tbl_cdb_pc", cdb_address[0], 32'h1000 + 32'(i * 4));
      chk("tbl_cdb_rrn", 32'(cdb_rrn[0]), 32'(i + 1));
      chk("tbl_cdb_we", 32'(cdb_we[0]), 32'(vt[i].e_we));
      chk("tbl_cdb_exc", 32'(cdb_exc[0]), 32'd0);
      tick();
      bus_select[0] = 4'h0;
      chk("tbl_popped", 32'(bus_req), 32'd0);
    end

    // Fill the queue without grants, then drain with multi-bus grants
    for (int j = 0; j < 4; j++) begin
      start_op(1'b0, 2'd2, 1'b0, 32'h300, 32'(j * 4), 32'h0, 32'h2000 + 32'(j), 6'(10 + j));
      ack_op(32'hA0000000 + 32'(j));
    end
    chk("fill_ready_low", 32'(feed_ready), 32'd0);
    chk("fill_bus_req", 32'(bus_req), 32'd3);
    feed_valid = 1'b1;
    tick();
    feed_valid = 1'b0;
    chk("fill_no_accept", 32'(dc_req), 32'd0);
    bus_select = {4'h3, 4'h3};
    #1;
    chk("drain2_drive", 32'(cdb_drive), 32'd3);
    chk("drain2_data0", cdb_data[0], 32'hA0000000);
    chk("drain2_data1", cdb_data[1], 32'hA0000001);
    chk("drain2_rrn1", 32'(cdb_rrn[1]), 32'd11);
    tick();
    bus_select = {4'h3, 4'h2};
    #1;
    chk("drain_ready_back", 32'(feed_ready), 32'd1);
    chk("drain_bus_req", 32'(bus_req), 32'd3);
    chk("drain1_drive", 32'(cdb_drive), 32'd2);
    chk("drain1_data1", cdb_data[1], 32'hA0000002);
    chk("drain1_idle_zero", cdb_data[0], 32'd0);
    tick();
    bus_select = {4'h3, 4'h3};
    #1;
    chk("drain_last_drive", 32'(cdb_drive), 32'd1);
    chk("drain_last_data", cdb_data[0], 32'hA0000003);
    chk("drain_last_pc", cdb_address[0], 32'h2003);
    chk("drain_bus1_zero", cdb_data[1], 32'd0);
    tick();
    bus_select = '0;
    chk("drain_empty", 32'(bus_req), 32'd0);

    // Push and pop in the same cycle
    start_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h40, 32'h0, 32'h3000, 6'd20);
    ack_op(32'h11111111);
    start_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h44, 32'h0, 32'h3004, 6'd21);
    dc_ack = 1'b1; dc_rdata = 32'h22222222; bus_select[0] = 4'h3;
    #1;
    chk("pp_old_data", cdb_data[0], 32'h11111111);
    tick();
    dc_ack = 1'b0;
    chk("pp_count1", 32'(bus_req), 32'd1);
    chk("pp_new_data", cdb_data[0], 32'h22222222);
    tick();
    bus_select = '0;
    chk("pp_empty", 32'(bus_req), 32'd0);

    // Flush with three queued entries and an access outstanding
    for (int j = 0; j < 3; j++) begin
      start_op(1'b0, 2'd2, 1'b0, 32'h0, 32'(j * 4), 32'h0, 32'h4000, 6'(j));
      ack_op(32'h30000000 + 32'(j));
    end
    start_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h80, 32'h0, 32'h4010, 6'd30);
    chk("fl_pre_req", 32'(dc_req), 32'd1);
    flush = 1'b1; dc_ack = 1'b1; dc_rdata = 32'h99999999;
    tick();
    flush = 1'b0; dc_ack = 1'b0;
    chk("fl_bus_req", 32'(bus_req), 32'd0);
    chk("fl_dc_req", 32'(dc_req), 32'd0);
    chk("fl_ready", 32'(feed_ready), 32'd1);
    bus_select = {4'h3, 4'h3};
    #1;
    chk("fl_no_drive", 32'(cdb_drive), 32'd0);
    bus_select = '0;
    start_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h84, 32'h0, 32'h4020, 6'd31);
    ack_op(32'h44444444);
    bus_select[0] = 4'h3;
    #1;
    chk("fl_after_data", cdb_data[0], 32'h44444444);
    chk("fl_after_rrn", 32'(cdb_rrn[0]), 32'd31);
    tick();
    bus_select = '0;

    // Reset asserted mid-access
    start_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h90, 32'h0, 32'h5000, 6'd1);
    chk("rstm_req_before", 32'(dc_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstm_req_async", 32'(dc_req), 32'd0);
    chk("rstm_addr_async", dc_addr, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rstm_ready", 32'(feed_ready), 32'd1);
    chk("rstm_idle", 32'(dc_req), 32'd0);
    chk("rstm_bus_req", 32'(bus_req), 32'd0);

    // Misaligned accesses
    start_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h1, 32'h0, 32'h6000, 6'd7);
`ifdef LS_MISALIGN_TRAP_EN
    chk("mis_no_req", 32'(dc_req), 32'd0);
    tick();
    chk("mis_queued", 32'(bus_req), 32'd1);
    bus_select[0] = 4'h3;
    #1;
    chk("mis_exc", 32'(cdb_exc[0]), 32'd1);
    chk("mis_data", cdb_data[0], 32'h101);
    chk("mis_we", 32'(cdb_we[0]), 32'd0);
`else
    chk("mis_req", 32'(dc_req), 32'd1);
    chk("mis_addr", dc_addr, 32'h100);
    chk("mis_be", 32'(dc_be), 32'hF);
    ack_op(32'h55667788);
    bus_select[0] = 4'h3;
    #1;
    chk("mis_exc", 32'(cdb_exc[0]), 32'd0);
    chk("mis_data", cdb_data[0], 32'h55667788);
    chk("mis_we", 32'(cdb_we[0]), 32'd1);
`endif
    tick();
    bus_select = '0;

    // Randomized run against the reference model
    begin
      logic        m_busy, m_tp, m_store, m_uns;
      logic [1:0]  m_size;
      logic [31:0] m_a, m_wd, m_pc;
      logic [5:0]  m_rrn;
      logic        exp_ready, exp_req;
      int          k;
      m_entry_t    e;
      m_busy = 1'b0; m_tp = 1'b0; m_store = 1'b0; m_uns = 1'b0;
      m_size = 2'd0; m_a = '0; m_wd = '0; m_pc = '0; m_rrn = '0;
      mq.delete();
      for (int c = 0; c < 600; c++) begin
        feed_valid    = 1'($urandom_range(0, 1));
        feed_size     = 2'($urandom_range(0, 2));
        feed_store    = 1'($urandom_range(0, 1));
        feed_unsigned = 1'($urandom_range(0, 1));
        feed_base     = $urandom;
        feed_offset   = 32'($urandom_range(0, 15));
        feed_data     = $urandom;
        feed_pc       = $urandom;
        feed_rrn      = 6'($urandom_range(0, 63));
        dc_rdata      = $urandom;
        dc_ack        = (m_busy && !m_tp) ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int i = 0; i < BC; i++)
          bus_select[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h3;
        #1;
        exp_ready = !m_busy && (mq.size() < 4);
        exp_req   = m_busy && !m_tp;
        chk("rnd_ready", 32'(feed_ready), 32'(exp_ready));
        chk("rnd_dc_req", 32'(dc_req), 32'(exp_req));
        if (exp_req) begin
          chk("rnd_dc_addr", dc_addr, m_a);
          chk("rnd_dc_be", 32'(dc_be), 32'(m_be(m_a, m_size)));
          chk("rnd_dc_we", 32'(dc_we), 32'(m_store));
          if (m_store) chk("rnd_dc_wdata", dc_wdata, m_wd);
        end
        k = 0;
        for (int i = 0; i < BC; i++) begin
          chk("rnd_bus_req", 32'(bus_req[i]), 32'(mq.size() > i));
          if (mq.size() > i && bus_select[i] == 4'h3) begin
            chk("rnd_drive", 32'(cdb_drive[i]), 32'd1);
            chk("rnd_data", cdb_data[i], mq[k].data);
            chk("rnd_pc", cdb_address[i], mq[k].pc);
            chk("rnd_rrn", 32'(cdb_rrn[i]), 32'(mq[k].rrn));
            chk("rnd_we", 32'(cdb_we[i]), 32'(mq[k].we));
            chk("rnd_exc", 32'(cdb_exc[i]), 32'(mq[k].exc));
            k++;
          end else begin
            chk("rnd_idle_bus", 32'(cdb_drive[i]) | cdb_data[i] | cdb_address[i]
                | 32'(cdb_rrn[i]) | 32'(cdb_we[i]) | 32'(cdb_exc[i]), 32'd0);
          end
        end
        for (int p = 0; p < k; p++) void'(mq.pop_front());
        if (m_busy && (m_tp || dc_ack)) begin
          e.pc = m_pc; e.rrn = m_rrn; e.exc = m_tp;
          if (m_tp) begin e.data = m_a; e.we = 1'b0; end
          else if (m_store) begin e.data = 32'd0; e.we = 1'b0; end
          else begin e.data = m_load(dc_rdata, m_a, m_size, m_uns); e.we = 1'b1; end
          mq.push_back(e);
          m_busy = 1'b0; m_tp = 1'b0;
        end else if (!m_busy && feed_valid && exp_ready) begin
          m_busy  = 1'b1;
          m_size  = feed_size; m_store = feed_store; m_uns = feed_unsigned;
          m_tp    = m_trap(feed_base + feed_offset, feed_size);
          m_a     = m_addr(feed_base + feed_offset, feed_size);
          m_wd    = m_wdata(feed_data, feed_size);
          m_pc    = feed_pc; m_rrn = feed_rrn;
        end
        @(posedge clk);
        #1;
      end
      feed_valid = 1'b0; dc_ack = 1'b0; bus_select = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_pipe.md
LOAD_STORE_PIPE -- requirements
Module: load_store_pipe

Interface
REQ-001 Parameters SHALL be: XLEN 32 (data/address width); BUS_COUNT 2 (common data buses served); QUEUE_DEPTH 4 (result queue entries, power of two, at least 2); RRN_WIDTH 6 (rename tag width); ARBITER_ADDRESS 4'h3 (bus-select code owned by this unit).
REQ-002 Timing is fixed: one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk, in, 1: clock.
- reset, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous pipeline flush.
- feed_valid, in, 1 / feed_ready, out, 1: operation handshake.
- feed_base, feed_data, feed_offset, feed_pc, in, XLEN: base, store data, immediate, instruction address.
- feed_rrn, in, RRN_WIDTH: destination tag.
- feed_store, in, 1: 1 = store, 0 = load.
- feed_size, in, 2: 0 byte, 1 half, 2 word.
- feed_unsigned, in, 1: zero-extend loads.
- dc_req, out, 1 / dc_we, out, 1 / dc_addr, out, XLEN / dc_wdata, out, XLEN / dc_be, out, 4: data-cache request.
- dc_ack, in, 1 / dc_rdata, in, XLEN: cache completion and read word.
- bus_select, in, BUS_COUNT x 4: per-bus arbiter winner code.
- bus_req, out, BUS_COUNT: request per bus.
- cdb_drive, out, BUS_COUNT: unit drives bus i this cycle.
- cdb_data, cdb_address, out, BUS_COUNT x XLEN: result and instruction address.
- cdb_rrn, out, BUS_COUNT x RRN_WIDTH: result tag.
- cdb_we, out, BUS_COUNT: register write enable.
- cdb_exc, out, BUS_COUNT: misaligned-access flag.

Function
REQ-004 The FSM SHALL have two states, IDLE and ACCESS. IDLE goes to ACCESS on feed_valid and feed_ready. ACCESS goes to IDLE on dc_ack.
REQ-005 feed_ready SHALL be 1 only when the state is IDLE and the registered queue count is below QUEUE_DEPTH.
REQ-006 On acceptance, the unit SHALL register the operation. dc_addr SHALL equal feed_base + feed_offset, modulo 2^XLEN.
REQ-007 In ACCESS, dc_req SHALL be 1 and dc_addr, dc_we, dc_wdata and dc_be SHALL be stable until dc_ack.
REQ-008 dc_be SHALL be the byte/half/word lane mask from addr[1:0], and dc_wdata SHALL be the store data replicated into the selected lanes.
REQ-009 On the dc_ack edge, the unit SHALL push one queue entry: data, pc, rrn, we, exc.
- Loads: data is the selected lane, sign- or zero-extended; we = 1.
- Stores: data = 0; we = 0.
REQ-010 Minimum latency SHALL be: accept at edge T, dc_req high after T, dc_ack at edge T+1, broadcast from the cycle after T+1.
REQ-011 bus_req[i] SHALL be 1 whenever the queue count exceeds i.
REQ-012 Bus i is granted when bus_select[i] equals ARBITER_ADDRESS and bus_req[i] is 1. The k-th granted bus in ascending index order SHALL carry the k-th oldest entry, with cdb_drive set.
REQ-013 The queue SHALL pop one entry per granted bus in the same cycle. Push and pop in one cycle SHALL be legal, and the count SHALL update by push minus pops.
REQ-014 When cdb_drive[i] is 0, all cdb_* fields of bus i SHALL be 0 (no tri-state).
REQ-015 Queue pointers SHALL wrap modulo QUEUE_DEPTH. A full queue SHALL never be pushed; this is guaranteed by REQ-005.
REQ-016 flush SHALL, at the next edge:
- empty the queue;
- return the FSM to IDLE;
- drop any dc_ack arriving that edge;
- leave outputs with dc_req = 0.

Reset
REQ-017 With reset low, the unit SHALL be in IDLE with queue count 0 and pointers 0. All outputs SHALL be 0 except feed_ready, which SHALL be 1 once reset is released.
REQ-018 Reset mid-access SHALL drop dc_req asynchronously and discard the operation.

Configuration
REQ-019 Macro LS_MISALIGN_TRAP_EN SHALL select misaligned-access handling:
- Defined: a misaligned half/word access SHALL skip the cache (no dc_req) and push an entry with exc = 1, we = 0, data = effective address in the next cycle.
- Undefined: address low bits SHALL be forced to the access alignment, and exc SHALL always be 0.

Structure
REQ-020 The shared package SHALL hold the size encoding enum, the FSM state enum, and the queue-entry struct.
REQ-021 One sub-module, ls_result_queue, SHALL implement the multi-pop FIFO with count.

Verification
REQ-022 Load word: base 0x100, offset 4, dc_rdata 0xDEADBEEF, ack on the first cycle, bus0 select 3 -> cdb_data[0] = 0xDEADBEEF, rrn broadcast one cycle after ack.
REQ-023 Signed byte load at addr 0x103, rdata 0x80xxxxxx -> data 0xFFFFFF80. With feed_unsigned = 1 -> data 0x00000080.
REQ-024 Store half 0x1234 at addr 0x2 -> dc_be 4'b1100, dc_wdata 0x12341234, broadcast we = 0.
REQ-025 Four loads with no grants -> feed_ready 0 at count 4. Then both buses granted for one cycle -> two pops, entries in order, count 2.
REQ-026 Flush with 3 queued entries and ACCESS pending -> count 0, dc_req 0, ack ignored. Reset asserted mid-ACCESS -> dc_req drops immediately.
REQ-027 With LS_MISALIGN_TRAP_EN, a word load at 0x101 -> no dc_req, exc = 1, data 0x101.
